// File: rtl/claw_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : claw_input_conditioner_if
// Description : Cabinet buttons and claw feedback in; motion commands,
//               strobes and round status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface claw_input_conditioner_if;
    logic       btn_fwd_raw;
    logic       btn_back_raw;
    logic       btn_drop_raw;
    logic       btn_start_raw;
    logic       claw_up;
    logic       forwards;
    logic       backwards;
    logic       claw_dropped_n;
    logic       start_game_n;
    logic [7:0] seconds_left;
    logic       game_active;

    // master is the conditioner itself; slave is the cabinet / motion side
    modport master (
        input  btn_fwd_raw, btn_back_raw, btn_drop_raw, btn_start_raw, claw_up,
        output forwards, backwards, claw_dropped_n, start_game_n,
               seconds_left, game_active
    );

    modport slave (
        output btn_fwd_raw, btn_back_raw, btn_drop_raw, btn_start_raw, claw_up,
        input  forwards, backwards, claw_dropped_n, start_game_n,
               seconds_left, game_active
    );
endinterface
`default_nettype wire

// File: rtl/claw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : claw_input_conditioner
// Description : Button sync/debounce, round countdown and IDLE/PLAY/DROPPED
//               sequencing in front of the claw motion controller.
// Revision    : 1.0 - initial release
// ============================================================================
module claw_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int GAME_SECONDS    = 30
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    claw_input_conditioner_if.master bus
);

    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [7:0]          c_GAME_SECS = 8'(GAME_SECONDS);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PLAY    = 2'd1;
    localparam logic [1:0] c_DROPPED = 2'd2;

    // bit order: 0 fwd, 1 back, 2 drop, 3 start
    logic [3:0] w_raw;
    logic [3:0] w_deb;

    assign w_raw = {bus.btn_start_raw, bus.btn_drop_raw, bus.btn_back_raw, bus.btn_fwd_raw};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_btn
            logic              r_meta;
            logic              r_sync;
            logic              r_level;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge CLK100MHZ) begin
                if (reset) begin
                    r_meta  <= 1'b0;
                    r_sync  <= 1'b0;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_meta <= w_raw[g];
                    r_sync <= r_meta;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[g] = r_level;
        end
    endgenerate

    logic [1:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [7:0]          r_secs;
    logic                r_prev_drop;
    logic                r_prev_start;
    logic                r_fwd;
    logic                r_back;
    logic                r_drop_n;
    logic                r_start_n;

    logic w_start_edge;
    logic w_drop_edge;
    logic w_wrap;
    logic w_drop_now;
    logic w_fwd_cmd;
    logic w_back_cmd;

    // edges run in every state so a button held across a transition is never seen as new
    assign w_start_edge = w_deb[3] & ~r_prev_start;
    assign w_drop_edge  = w_deb[2] & ~r_prev_drop;
    assign w_wrap       = (r_state == c_PLAY) && (r_tick == c_TICK_LAST);
    assign w_drop_now   = (r_state == c_PLAY) && (w_drop_edge || (w_wrap && r_secs == 8'd1));
    assign w_fwd_cmd    = w_deb[0] & ~w_deb[1];
    assign w_back_cmd   = w_deb[1] & ~w_deb[0];

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_tick       <= '0;
            r_secs       <= 8'd0;
            r_prev_drop  <= 1'b0;
            r_prev_start <= 1'b0;
            r_fwd        <= 1'b0;
            r_back       <= 1'b0;
            r_drop_n     <= 1'b1;
            r_start_n    <= 1'b1;
        end else begin
            r_prev_drop  <= w_deb[2];
            r_prev_start <= w_deb[3];
            r_fwd        <= 1'b0;
            r_back       <= 1'b0;
            r_drop_n     <= 1'b1;
            r_start_n    <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_start_edge) begin
                        r_start_n <= 1'b0;
                        r_secs    <= c_GAME_SECS;
                        r_tick    <= '0;
                        r_fwd     <= w_fwd_cmd;
                        r_back    <= w_back_cmd;
                        r_state   <= c_PLAY;
                    end
                end
                c_PLAY: begin
                    if (w_drop_now) begin
                        r_drop_n <= 1'b0;
                        r_secs   <= 8'd0;
                        r_state  <= c_DROPPED;
                    end else begin
                        r_fwd  <= w_fwd_cmd;
                        r_back <= w_back_cmd;
                        if (w_wrap) begin
                            r_tick <= '0;
                            if (r_secs != 8'd0) begin
                                r_secs <= r_secs - 8'd1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                c_DROPPED: begin
                    if (bus.claw_up) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.forwards       = r_fwd;
    assign bus.backwards      = r_back;
    assign bus.claw_dropped_n = r_drop_n;
    assign bus.start_game_n   = r_start_n;
    assign bus.seconds_left   = r_secs;
    assign bus.game_active    = (r_state == c_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_claw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_claw_input_conditioner
// Description : Directed self-checking bench for claw_input_conditioner
//               (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, GAME_SECONDS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_claw_input_conditioner;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_start;
    int   n_drop;

    claw_input_conditioner_if bus ();

    claw_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .TICK_CYCLES     (10),
        .GAME_SECONDS    (3)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobes are one cycle wide, so one count per pulse
    always @(negedge clk) begin
        if (bus.start_game_n === 1'b0) n_start <= n_start + 1;
        if (bus.claw_dropped_n === 1'b0) n_drop <= n_drop + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.btn_fwd_raw   = 1'b0;
        bus.btn_back_raw  = 1'b0;
        bus.btn_drop_raw  = 1'b0;
        bus.btn_start_raw = 1'b0;
        bus.claw_up       = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // returns sampled just after the start strobe edge, with start released
    task automatic press_start(output bit found);
        found = 1'b0;
        bus.btn_start_raw = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (bus.start_game_n === 1'b0) found = 1'b1;
        end
        bus.btn_start_raw = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        step(1);
        n_checks += 6;
        if (bus.forwards !== 1'b0) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0", bus.forwards); end
        if (bus.backwards !== 1'b0) begin n_fail++; $display("FAIL reset_back: got %b expected 0", bus.backwards); end
        if (bus.claw_dropped_n !== 1'b1) begin n_fail++; $display("FAIL reset_drop_n: got %b expected 1", bus.claw_dropped_n); end
        if (bus.start_game_n !== 1'b1) begin n_fail++; $display("FAIL reset_start_n: got %b expected 1", bus.start_game_n); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL reset_secs: got %0d expected 0", bus.seconds_left); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", bus.game_active); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = n_start;
        for (int i = 0; i < 5; i++) begin
            bus.btn_start_raw = 1'b1;
            step(2);
            bus.btn_start_raw = 1'b0;
            step(2);
        end
        bus.btn_start_raw = 1'b1;
        step(6);
        n_checks += 2;
        if (n_start !== base) begin n_fail++; $display("FAIL bounce_no_early: got %0d pulses expected 0", n_start - base); end
        if (bus.start_game_n !== 1'b1) begin n_fail++; $display("FAIL bounce_cycle6: got %b expected 1", bus.start_game_n); end
        step(1);
        n_checks += 3;
        if (bus.start_game_n !== 1'b0) begin n_fail++; $display("FAIL bounce_strobe: got %b expected 0", bus.start_game_n); end
        if (bus.seconds_left !== 8'd3) begin n_fail++; $display("FAIL bounce_secs: got %0d expected 3", bus.seconds_left); end
        if (bus.game_active !== 1'b1) begin n_fail++; $display("FAIL bounce_active: got %b expected 1", bus.game_active); end
        step(1);
        n_checks += 2;
        if (bus.start_game_n !== 1'b1) begin n_fail++; $display("FAIL bounce_width: got %b expected 1", bus.start_game_n); end
        if (n_start !== base + 1) begin n_fail++; $display("FAIL bounce_count: got %0d pulses expected 1", n_start - base); end
        bus.btn_start_raw = 1'b0;
    endtask

    task automatic test_direction();
        bit found;
        do_reset();
        press_start(found);
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL dir_start: got no strobe expected strobe"); end
        bus.btn_fwd_raw = 1'b1;
        step(7);
        n_checks += 2;
        if (bus.forwards !== 1'b1) begin n_fail++; $display("FAIL dir_fwd: got %b expected 1", bus.forwards); end
        if (bus.backwards !== 1'b0) begin n_fail++; $display("FAIL dir_fwd_back: got %b expected 0", bus.backwards); end
        bus.btn_back_raw = 1'b1;
        step(7);
        n_checks += 2;
        if (bus.forwards !== 1'b0) begin n_fail++; $display("FAIL dir_both_fwd: got %b expected 0", bus.forwards); end
        if (bus.backwards !== 1'b0) begin n_fail++; $display("FAIL dir_both_back: got %b expected 0", bus.backwards); end
        bus.btn_fwd_raw = 1'b0;
        step(7);
        n_checks += 3;
        if (bus.forwards !== 1'b0) begin n_fail++; $display("FAIL dir_back_fwd: got %b expected 0", bus.forwards); end
        if (bus.backwards !== 1'b1) begin n_fail++; $display("FAIL dir_back: got %b expected 1", bus.backwards); end
        if (bus.seconds_left !== 8'd1) begin n_fail++; $display("FAIL dir_secs: got %0d expected 1", bus.seconds_left); end
        bus.btn_back_raw = 1'b0;
    endtask

    task automatic test_timeout();
        bit found;
        int base;
        do_reset();
        press_start(found);
        base = n_drop;
        n_checks += 2;
        if (!found) begin n_fail++; $display("FAIL to_start: got no strobe expected strobe"); end
        if (bus.seconds_left !== 8'd3) begin n_fail++; $display("FAIL to_secs3: got %0d expected 3", bus.seconds_left); end
        step(9);
        n_checks++;
        if (bus.seconds_left !== 8'd3) begin n_fail++; $display("FAIL to_secs3_hold: got %0d expected 3", bus.seconds_left); end
        step(1);
        n_checks++;
        if (bus.seconds_left !== 8'd2) begin n_fail++; $display("FAIL to_secs2: got %0d expected 2", bus.seconds_left); end
        step(10);
        n_checks++;
        if (bus.seconds_left !== 8'd1) begin n_fail++; $display("FAIL to_secs1: got %0d expected 1", bus.seconds_left); end
        step(9);
        n_checks += 2;
        if (bus.claw_dropped_n !== 1'b1) begin n_fail++; $display("FAIL to_early: got %b expected 1", bus.claw_dropped_n); end
        if (bus.game_active !== 1'b1) begin n_fail++; $display("FAIL to_active29: got %b expected 1", bus.game_active); end
        step(1);
        n_checks += 3;
        if (bus.claw_dropped_n !== 1'b0) begin n_fail++; $display("FAIL to_strobe: got %b expected 0", bus.claw_dropped_n); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL to_secs0: got %0d expected 0", bus.seconds_left); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL to_active: got %b expected 0", bus.game_active); end
        step(12);
        n_checks += 2;
        if (n_drop !== base + 1) begin n_fail++; $display("FAIL to_count: got %0d pulses expected 1", n_drop - base); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL to_frozen: got %0d expected 0", bus.seconds_left); end
    endtask

    task automatic test_simultaneous();
        bit found;
        int base;
        do_reset();
        press_start(found);
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL sim_start: got no strobe expected strobe"); end
        step(23);
        base = n_drop;
        bus.btn_drop_raw = 1'b1;
        step(6);
        n_checks += 2;
        if (bus.claw_dropped_n !== 1'b1) begin n_fail++; $display("FAIL sim_early: got %b expected 1", bus.claw_dropped_n); end
        if (bus.seconds_left !== 8'd1) begin n_fail++; $display("FAIL sim_secs1: got %0d expected 1", bus.seconds_left); end
        step(1);
        n_checks += 2;
        if (bus.claw_dropped_n !== 1'b0) begin n_fail++; $display("FAIL sim_strobe: got %b expected 0", bus.claw_dropped_n); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL sim_secs0: got %0d expected 0", bus.seconds_left); end
        step(3);
        n_checks++;
        if (n_drop !== base + 1) begin n_fail++; $display("FAIL sim_count: got %0d pulses expected 1", n_drop - base); end
        bus.btn_drop_raw = 1'b0;
        bus.claw_up = 1'b1;
        step(1);
        bus.claw_up = 1'b0;
        step(1);
        press_start(found);
        n_checks += 3;
        if (!found) begin n_fail++; $display("FAIL sim_restart: got no strobe expected strobe"); end
        if (bus.seconds_left !== 8'd3) begin n_fail++; $display("FAIL sim_reload: got %0d expected 3", bus.seconds_left); end
        if (bus.game_active !== 1'b1) begin n_fail++; $display("FAIL sim_active: got %b expected 1", bus.game_active); end
    endtask

    task automatic test_held_ignored();
        bit found;
        int base_s;
        int base_d;
        do_reset();
        bus.btn_drop_raw = 1'b1;
        step(8);
        press_start(found);
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL held_start: got no strobe expected strobe"); end
        step(10);
        base_s = n_start;
        base_d = n_drop;
        n_checks += 3;
        if (n_drop !== 0 && bus.game_active !== 1'b1) begin n_fail++; $display("FAIL held_no_drop: got active %b expected 1", bus.game_active); end
        if (bus.game_active !== 1'b1) begin n_fail++; $display("FAIL held_active: got %b expected 1", bus.game_active); end
        if (bus.seconds_left !== 8'd2) begin n_fail++; $display("FAIL held_secs2: got %0d expected 2", bus.seconds_left); end
        bus.btn_start_raw = 1'b1;
        bus.btn_drop_raw  = 1'b0;
        step(8);
        n_checks += 3;
        if (n_start !== base_s) begin n_fail++; $display("FAIL play_start_strobe: got %0d pulses expected 0", n_start - base_s); end
        if (bus.seconds_left !== 8'd2) begin n_fail++; $display("FAIL play_start_reload: got %0d expected 2", bus.seconds_left); end
        if (n_drop !== base_d) begin n_fail++; $display("FAIL held_release_drop: got %0d pulses expected 0", n_drop - base_d); end
        bus.btn_start_raw = 1'b0;
        bus.btn_drop_raw  = 1'b1;
        step(7);
        n_checks += 2;
        if (bus.claw_dropped_n !== 1'b0) begin n_fail++; $display("FAIL repress_drop: got %b expected 0", bus.claw_dropped_n); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL repress_secs: got %0d expected 0", bus.seconds_left); end
        bus.btn_start_raw = 1'b1;
        bus.btn_drop_raw  = 1'b0;
        step(8);
        n_checks += 3;
        if (n_start !== base_s) begin n_fail++; $display("FAIL dropped_start_strobe: got %0d pulses expected 0", n_start - base_s); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL dropped_reload: got %0d expected 0", bus.seconds_left); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL dropped_active: got %b expected 0", bus.game_active); end
        bus.btn_start_raw = 1'b0;
        bus.claw_up = 1'b1;
        step(1);
        bus.claw_up = 1'b0;
        step(8);
        n_checks += 2;
        if (n_start !== base_s) begin n_fail++; $display("FAIL edge_queued: got %0d pulses expected 0", n_start - base_s); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b expected 0", bus.game_active); end
    endtask

    task automatic test_mid_reset();
        bit found;
        int base_s;
        int base_d;
        do_reset();
        press_start(found);
        bus.btn_fwd_raw = 1'b1;
        step(12);
        n_checks += 3;
        if (!found) begin n_fail++; $display("FAIL mr_start: got no strobe expected strobe"); end
        if (bus.forwards !== 1'b1) begin n_fail++; $display("FAIL mr_pre_fwd: got %b expected 1", bus.forwards); end
        if (bus.seconds_left !== 8'd2) begin n_fail++; $display("FAIL mr_pre_secs: got %0d expected 2", bus.seconds_left); end
        base_s = n_start;
        base_d = n_drop;
        reset = 1'b1;
        step(1);
        n_checks += 6;
        if (bus.forwards !== 1'b0) begin n_fail++; $display("FAIL mr_fwd: got %b expected 0", bus.forwards); end
        if (bus.backwards !== 1'b0) begin n_fail++; $display("FAIL mr_back: got %b expected 0", bus.backwards); end
        if (bus.claw_dropped_n !== 1'b1) begin n_fail++; $display("FAIL mr_drop_n: got %b expected 1", bus.claw_dropped_n); end
        if (bus.start_game_n !== 1'b1) begin n_fail++; $display("FAIL mr_start_n: got %b expected 1", bus.start_game_n); end
        if (bus.seconds_left !== 8'd0) begin n_fail++; $display("FAIL mr_secs: got %0d expected 0", bus.seconds_left); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL mr_active: got %b expected 0", bus.game_active); end
        reset = 1'b0;
        step(10);
        n_checks += 3;
        if (bus.forwards !== 1'b0) begin n_fail++; $display("FAIL mr_idle_fwd: got %b expected 0", bus.forwards); end
        if (bus.game_active !== 1'b0) begin n_fail++; $display("FAIL mr_idle_active: got %b expected 0", bus.game_active); end
        if (n_start !== base_s || n_drop !== base_d) begin n_fail++; $display("FAIL mr_strobes: got %0d/%0d pulses expected 0/0", n_start - base_s, n_drop - base_d); end
        bus.btn_fwd_raw = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_start  = 0;
        n_drop   = 0;
        reset    = 1'b1;
        bus.btn_fwd_raw   = 1'b0;
        bus.btn_back_raw  = 1'b0;
        bus.btn_drop_raw  = 1'b0;
        bus.btn_start_raw = 1'b0;
        bus.claw_up       = 1'b0;
        test_reset();
        test_bounce();
        test_direction();
        test_timeout();
        test_simultaneous();
        test_held_ignored();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
